// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, FSM states and limits for the configurable UART transmitter.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;
   localparam int MIN_DATA_BITS = 5;
   localparam logic [2:0] PAR_NONE  = 3'd0;
   localparam logic [2:0] PAR_EVEN  = 3'd1;
   localparam logic [2:0] PAR_ODD   = 3'd2;
   localparam logic [2:0] PAR_MARK  = 3'd3;
   localparam logic [2:0] PAR_SPACE = 3'd4;
   localparam logic [1:0] STOP_1    = 2'd0;
   localparam logic [1:0] STOP_1P5  = 2'd1;
   localparam logic [1:0] STOP_2    = 2'd2;
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
`ifdef UART_TX_BREAK_EN
      , S_BREAK
`endif
   } state_t;
endpackage

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (5..MaxDataBits, parity, 1/1.5/2 stop) with valid/ready input.
// Define UART_TX_BREAK_EN to add break_i and line-break generation with mark-after-break.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int MaxDataBits = 9,
   parameter int Oversample  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sample_tick_i,
`ifdef UART_TX_BREAK_EN
   input  logic                   break_i,
`endif
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [MaxDataBits-1:0] din_i,
   input  logic [3:0]             data_bits_i,
   input  logic [2:0]             parity_i,
   input  logic [1:0]             stop_i,
   output logic                   tx_o,
   output logic                   busy_o,
   output logic                   tx_done_o
);
   localparam int TW = $clog2(2 * Oversample);
   localparam int BW = $clog2(MaxDataBits);
   state_t state, state_n;
   logic [TW-1:0] tcnt, tcnt_n, stop_len;
   logic [BW-1:0] bcnt, bcnt_n;
   logic [MaxDataBits-1:0] sh, sh_n, mask, word;
   logic [3:0] nb, nb_q;
   logic [1:0] stop_q;
   logic par_en_q, par_q, tx_q, tx_n, brk, accept, tick_end, last_bit;
`ifdef UART_TX_BREAK_EN
   assign brk = break_i;
`else
   assign brk = 1'b0;
`endif
   assign ready_o   = state == S_IDLE && !brk;
   assign accept    = valid_i && ready_o;
   assign busy_o    = state != S_IDLE;
   assign tx_o      = tx_q;
   assign nb        = data_bits_i < 4'(MIN_DATA_BITS) ? 4'(MIN_DATA_BITS) :
                      data_bits_i > 4'(MaxDataBits) ? 4'(MaxDataBits) : data_bits_i;
   assign mask      = MaxDataBits'((1 << nb) - 1);
   assign word      = din_i & mask;
   assign stop_len  = stop_q < STOP_2 ? (stop_q == STOP_1 ? TW'(Oversample - 1) : TW'(3 * Oversample / 2 - 1))
                                      : TW'(2 * Oversample - 1);
   assign tick_end  = sample_tick_i && tcnt == (state == S_STOP ? stop_len : TW'(Oversample - 1));
   assign last_bit  = bcnt == BW'(nb_q - 4'd1);
   assign tx_done_o = state == S_STOP && tick_end;
   always_comb begin
      state_n = state;
      tx_n    = tx_q;
      bcnt_n  = bcnt;
      sh_n    = sh;
      tcnt_n  = (state != S_IDLE && sample_tick_i) ? (tick_end ? '0 : tcnt + 1'b1) : tcnt;
      case (state)
         S_IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (brk) begin
               state_n = S_BREAK;
               tx_n    = 1'b0;
               tcnt_n  = '0;
            end else
`endif
            if (accept) begin
               state_n = S_START;
               tx_n    = 1'b0;
               tcnt_n  = '0;
               bcnt_n  = '0;
               sh_n    = word;
            end
         end
         S_START: if (tick_end) begin
            state_n = S_DATA;
            tx_n    = sh[0];
         end
         S_DATA: if (tick_end) begin
            if (last_bit) begin
               state_n = par_en_q ? S_PARITY : S_STOP;
               tx_n    = par_en_q ? par_q : 1'b1;
            end else begin
               bcnt_n = bcnt + 1'b1;
               sh_n   = sh >> 1;
               tx_n   = sh[1];
            end
         end
         S_PARITY: if (tick_end) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
         end
         S_STOP: if (tick_end) state_n = S_IDLE;
`ifdef UART_TX_BREAK_EN
         // line held low while break_i is high, then one bit time of mark before IDLE
         S_BREAK: begin
            tx_n = !brk;
            if (brk) tcnt_n = '0;
            else if (tick_end) state_n = S_IDLE;
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         tx_q     <= 1'b1;
         tcnt     <= '0;
         bcnt     <= '0;
         sh       <= '0;
         nb_q     <= 4'(MIN_DATA_BITS);
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop_q   <= STOP_1;
      end else begin
         state <= state_n;
         tx_q  <= tx_n;
         tcnt  <= tcnt_n;
         bcnt  <= bcnt_n;
         sh    <= sh_n;
         if (accept) begin
            nb_q     <= nb;
            stop_q   <= stop_i;
            par_en_q <= parity_i != PAR_NONE && parity_i <= PAR_SPACE;
            par_q    <= parity_i == PAR_EVEN ? ^word : parity_i == PAR_ODD ? ~^word : parity_i == PAR_MARK;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: randomized self-checking bench; frames are predicted tick-by-tick from the line format rules.
// Define UART_TX_BREAK_EN to also exercise break generation.
module tb_uart_tx_cfg;
   localparam int OS = 16;
   logic clk = 1'b0, rst = 1'b1, tick = 1'b1, valid = 1'b0, brk = 1'b0;
   logic ready, tx, busy, done;
   logic [8:0] din = '0;
   logic [3:0] data_bits = 4'd8;
   logic [2:0] parity = 3'd0;
   logic [1:0] stop = 2'd0;
   bit tick_all = 1'b1;
   int checks = 0, errors = 0;
   bit expq[$], obsq[$];
   int done_tick, done_cnt, busy_low, ready_hi;
   uart_tx_cfg #(.MaxDataBits(9), .Oversample(OS)) dut (
      .clk_i(clk), .rst_i(rst), .sample_tick_i(tick),
`ifdef UART_TX_BREAK_EN
      .break_i(brk),
`endif
      .valid_i(valid), .ready_o(ready), .din_i(din), .data_bits_i(data_bits),
      .parity_i(parity), .stop_i(stop), .tx_o(tx), .busy_o(busy), .tx_done_o(done)
   );
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      #1 tick = tick_all || ($urandom_range(2) == 0);
   end
   // expected line level for every sample tick of one frame
   function automatic void build_exp(input logic [8:0] d, input int nb_in, input int p, input int s);
      int nb, ones;
      bit pb;
      nb   = nb_in < 5 ? 5 : nb_in > 9 ? 9 : nb_in;
      ones = 0;
      expq = {};
      repeat (OS) expq.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         repeat (OS) expq.push_back(d[i]);
         ones += d[i];
      end
      if (p >= 1 && p <= 4) begin
         pb = p == 1 ? ones[0] : p == 2 ? !ones[0] : p == 3;
         repeat (OS) expq.push_back(pb);
      end
      repeat (s == 0 ? OS : s == 1 ? OS * 3 / 2 : 2 * OS) expq.push_back(1'b1);
   endfunction
   function automatic int first_diff();
      for (int i = 0; i < expq.size(); i++)
         if (i >= obsq.size() || obsq[i] !== expq[i]) return i;
      return obsq.size() == expq.size() ? -1 : expq.size();
   endfunction
   task automatic start_frame(input logic [8:0] d, input logic [3:0] nb, input logic [2:0] p, input logic [1:0] s);
      @(negedge clk);
      din = d; data_bits = nb; parity = p; stop = s; valid = 1'b1;
      for (int i = 0; i < 500 && !ready; i++) @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout ready=%b expected 1", ready);
      end
      @(posedge clk);
      #1 valid = 1'b0;
      din = 9'($urandom); data_bits = 4'($urandom); parity = 3'($urandom); stop = 2'($urandom);
   endtask
   task automatic capture();
      obsq = {}; done_tick = -1; done_cnt = 0; busy_low = 0; ready_hi = 0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (!busy) busy_low++;
         if (ready) ready_hi++;
         if (tick) obsq.push_back(tx);
         if (done) begin
            done_cnt++;
            done_tick = obsq.size();
            break;
         end
      end
   endtask
   task automatic test_reset();
      @(negedge clk);
      checks += 4;
      if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx got %b expected 1", tx); end
      if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b expected 0", done); end
      rst = 1'b0;
   endtask
   task automatic test_8n1();
      int d;
      tick_all = 1'b1;
      build_exp(9'h0A5, 8, 0, 0);
      start_frame(9'h0A5, 4'd8, 3'd0, 2'd0);
      capture();
      d = first_diff();
      checks += 4;
      if (d != -1) begin errors++; $display("FAIL frame_8n1 diff at tick %0d got len %0d expected len %0d", d, obsq.size(), expq.size()); end
      if (done_tick != 160) begin errors++; $display("FAIL done_8n1 got tick %0d expected 160", done_tick); end
      if (busy_low != 0) begin errors++; $display("FAIL busy_8n1 got %0d idle cycles expected 0", busy_low); end
      @(negedge clk);
      if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_8n1 got %b expected 1", ready); end
   endtask
   task automatic test_parity();
      int d;
      for (int p = 1; p <= 5; p++) begin
         build_exp(9'h003, 7, p, 0);
         start_frame(9'h003, 4'd7, 3'(p), 2'd0);
         capture();
         d = first_diff();
         checks += 2;
         if (d != -1) begin errors++; $display("FAIL frame_7par%0d diff at tick %0d got len %0d expected len %0d", p, d, obsq.size(), expq.size()); end
         if (done_cnt != 1) begin errors++; $display("FAIL done_7par%0d got %0d pulses expected 1", p, done_cnt); end
      end
   endtask
   task automatic test_short_stop();
      int d;
      build_exp(9'h1E5, 5, 0, 1);
      start_frame(9'h1E5, 4'd5, 3'd0, 2'd1);
      capture();
      d = first_diff();
      checks += 2;
      if (d != -1) begin errors++; $display("FAIL frame_5n15 diff at tick %0d got len %0d expected len %0d", d, obsq.size(), expq.size()); end
      if (done_tick != 120) begin errors++; $display("FAIL done_5n15 got tick %0d expected 120", done_tick); end
   endtask
   task automatic test_random();
      logic [8:0] rd;
      logic [3:0] rn;
      logic [2:0] rp;
      logic [1:0] rs;
      int d;
      tick_all = 1'b0;
      for (int k = 0; k < 10; k++) begin
         rd = 9'($urandom); rn = 4'($urandom); rp = 3'($urandom); rs = 2'($urandom);
         build_exp(rd, rn, rp, rs);
         start_frame(rd, rn, rp, rs);
         capture();
         d = first_diff();
         checks += 2;
         if (d != -1) begin errors++; $display("FAIL frame_rand%0d d=%h nb=%0d p=%0d s=%0d diff at %0d got len %0d expected len %0d", k, rd, rn, rp, rs, d, obsq.size(), expq.size()); end
         if (done_cnt != 1 || busy_low != 0) begin errors++; $display("FAIL done_rand%0d got pulses %0d idle %0d expected 1 0", k, done_cnt, busy_low); end
      end
      tick_all = 1'b1;
   endtask
   task automatic test_back_to_back();
      int d;
      @(negedge clk);
      din = 9'h055; data_bits = 4'd8; parity = 3'd0; stop = 2'd0; valid = 1'b1;
      for (int i = 0; i < 500 && !ready; i++) @(negedge clk);
      @(posedge clk);
      #1 din = 9'h0AA; parity = 3'd2;
      build_exp(9'h055, 8, 0, 0);
      capture();
      d = first_diff();
      checks += 5;
      if (d != -1) begin errors++; $display("FAIL frame_b2b1 diff at tick %0d got len %0d expected len %0d", d, obsq.size(), expq.size()); end
      if (ready_hi != 0) begin errors++; $display("FAIL ready_during_b2b1 got %0d cycles expected 0", ready_hi); end
      @(negedge clk);
      if (ready !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL gap_b2b got ready %b tx %b expected 1 1", ready, tx); end
      @(posedge clk);
      #1 valid = 1'b0;
      build_exp(9'h0AA, 8, 2, 0);
      capture();
      d = first_diff();
      if (d != -1) begin errors++; $display("FAIL frame_b2b2 diff at tick %0d got len %0d expected len %0d", d, obsq.size(), expq.size()); end
      if (ready_hi != 0 || done_cnt != 1) begin errors++; $display("FAIL ready_b2b2 got ready %0d done %0d expected 0 1", ready_hi, done_cnt); end
   endtask
   task automatic test_reset_mid();
      int d, pulses;
      start_frame(9'h000, 4'd8, 3'd1, 2'd0);
      repeat (70) @(negedge clk);
      rst = 1'b1;
      pulses = done;
      @(negedge clk);
      rst = 1'b0;
      checks += 5;
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid got tx %b ready %b busy %b expected 1 1 0", tx, ready, busy); end
      repeat (200) begin
         @(negedge clk);
         pulses += done;
      end
      if (pulses != 0) begin errors++; $display("FAIL reset_mid_done got %0d pulses expected 0", pulses); end
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_line got %b expected 1", tx); end
      build_exp(9'h13C, 9, 2, 2);
      start_frame(9'h13C, 4'd9, 3'd2, 2'd2);
      capture();
      d = first_diff();
      if (d != -1) begin errors++; $display("FAIL frame_after_reset diff at tick %0d got len %0d expected len %0d", d, obsq.size(), expq.size()); end
      if (done_tick != expq.size()) begin errors++; $display("FAIL done_after_reset got tick %0d expected %0d", done_tick, expq.size()); end
   endtask
`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      int lows, highs, rdy;
      lows = 0; highs = 0; rdy = 0;
      @(negedge clk);
      brk = 1'b1; valid = 1'b1; din = 9'h0F0; data_bits = 4'd8; parity = 3'd0; stop = 2'd0;
      rdy += ready;
      repeat (50) begin
         @(negedge clk);
         lows += !tx;
         rdy += ready;
      end
      brk = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!tx) break;
         highs++;
      end
      valid = 1'b0;
      checks += 4;
      if (lows != 50) begin errors++; $display("FAIL break_low got %0d expected 50", lows); end
      if (highs != 16) begin errors++; $display("FAIL break_mark got %0d expected 16", highs); end
      if (rdy != 0) begin errors++; $display("FAIL break_ready got %0d cycles expected 0", rdy); end
      capture();
      if (done_cnt != 1) begin errors++; $display("FAIL break_frame_done got %0d expected 1", done_cnt); end
   endtask
`endif
   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_8n1();
      test_parity();
      test_short_stop();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
